// File: rtl/spi_master_tx.sv
// SPI master transmitter, mode 0 (sclk idles low, data changes on the falling
// edge, sampled on the rising edge), MSB first.
// Pops words from the read side of a TX FIFO, shifts them out on mosi with
// cs_n framing, and captures miso into rx_data for full-duplex use.
//
// Ports
//   rd_clk, rd_rst_n   clock, async active-low reset
//   tx_enable          permits starting/continuing a frame
//   rd_empty, rd_data  FIFO status and read data (data valid cycle after rd_en)
//   rd_en              one-cycle FIFO read strobe
//   sclk, cs_n, mosi   SPI bus outputs (all registered)
//   miso               SPI input, 2-flop synchronised
//   rx_data, rx_valid  last received word and its one-cycle strobe
//   busy               high whenever the FSM is not in IDLE
//
// Note: miso goes through two sync flops before the rising-edge sample, so a
// slave that changes miso on the falling edge is only captured correctly with
// CLK_DIV >= 3.
module spi_master_tx #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              tx_enable,
  input  logic              rd_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

  // One shared cycle counter covers every timed state; HOLD counts to CS_HOLD
  // inclusive (the falling-edge cycle plus CS_HOLD more).
  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (CS_HOLD + 1 > CS_GAP) ? CS_HOLD + 1 : CS_GAP;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;     // 0: low phase, 1: high phase
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic                miso_meta, miso_s;
  logic                sclk_d, cs_n_d, mosi_d, rd_en_d, rx_valid_d, busy_d;
  logic [DATA_W-1:0]   rx_data_d;
  logic                start;

  assign start = tx_enable && !rd_empty;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      rd_en      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      sclk       <= sclk_d;
      cs_n       <= cs_n_d;
      mosi       <= mosi_d;
      rd_en      <= rd_en_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    sclk_d     = sclk;
    cs_n_d     = cs_n;
    mosi_d     = mosi;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = rd_data;
        mosi_d  = rd_data[DATA_W-1];
        bit_d   = BIT_W'(DATA_W - 1);
        cnt_d   = '0;
        phase_d = 1'b0;
        // cs_n already low means a back-to-back word: skip the setup time
        if (!cs_n) begin
          state_d = SHIFT;
        end else begin
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_W'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            // rising edge: sample the slave
            phase_d    = 1'b1;
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso_s};
          end else begin
            // falling edge: next bit out, or word boundary
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q != '0) begin
              shift_d = shift_q << 1;
              mosi_d  = shift_q[DATA_W-2];
              bit_d   = bit_q - BIT_W'(1);
            end else begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              state_d    = start ? FETCH : HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // registered strobes follow the state being entered
    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: FIFO model, bus monitor, slave model, vector table,
// hand-written corner sequences and randomized multi-byte frames.
module tb_spi_master_tx;
  localparam int DW       = 8;
  localparam int CD       = 4;
  localparam int SU       = 2;
  localparam int HD       = 2;
  localparam int GP       = 2;
  localparam int BYTE_CYC = 2 * CD * DW;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic          tx_enable = 1'b0;
  logic          rd_empty, rd_en, sclk, cs_n, mosi, miso, rx_valid, busy;
  logic [DW-1:0] rd_data, rx_data;

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HD), .CS_GAP(GP)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .tx_enable(tx_enable), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_en(rd_en), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rd_empty = (rd_ptr == wr_ptr);
  always @(posedge rd_clk) if (rd_en) begin
    rd_data <= mem[rd_ptr[7:0]];
    rd_ptr  <= rd_ptr + 1;
  end

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  // ---------------- slave / loopback ----------------
  logic          loop_en = 1'b1;
  logic [DW-1:0] slave_pat = '0;
  logic          slave_bit = 1'b0;
  assign miso = loop_en ? mosi : slave_bit;

  // ---------------- bus monitor ----------------
  int   n_rise = 0, n_rden = 0, inv_err = 0, hi_bad = 0;
  logic rise_bits[$];
  logic [DW-1:0] rx_q[$];
  logic rv_fall_q[$];
  int   cs_len_q[$];
  int   low_run_q[$];
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_empty = 1'b1;
  int   cs_run = 0, lo_run = 0, hi_run = 0, s_idx = 0;

  task automatic mon_step();
    if (sclk && !prev_sclk) begin
      rise_bits.push_back(mosi);
      low_run_q.push_back(lo_run);
      n_rise++;
    end
    if ((sclk != prev_sclk) && cs_n && prev_cs) begin
      inv_err++;
      $display("FAIL sclk_toggle_with_cs_high: sclk=%0b cs_n=%0b required cs_n=0", sclk, cs_n);
    end
    if (sclk && prev_sclk && (mosi !== prev_mosi)) begin
      inv_err++;
      $display("FAIL mosi_stable_high: mosi=%0b required %0b", mosi, prev_mosi);
    end
    if (rd_en) begin
      n_rden++;
      if (prev_empty || sclk) begin
        inv_err++;
        $display("FAIL rd_en_legal: prev_empty=%0b sclk=%0b required 0/0", prev_empty, sclk);
      end
    end
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rv_fall_q.push_back(!sclk && prev_sclk);
    end
    if (!cs_n) cs_run++;
    else begin
      if (!prev_cs) cs_len_q.push_back(cs_run);
      cs_run = 0;
    end
    if (sclk) hi_run = prev_sclk ? hi_run + 1 : 1;
    else if (prev_sclk && rd_rst_n && hi_run != CD) hi_bad++;
    if (!cs_n && !sclk) lo_run = prev_sclk ? 1 : lo_run + 1;
    else if (cs_n) lo_run = 0;
    // slave drives the next bit after each falling edge
    if (cs_n) s_idx = 0;
    else if (prev_sclk && !sclk) s_idx++;
    slave_bit = slave_pat[DW - 1 - (s_idx % DW)];
    prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi; prev_empty = rd_empty;
  endtask

  initial forever begin
    @(negedge rd_clk);
    mon_step();
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === lvl) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rise(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_rise >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic run_frame(output bit ok);
    bit a, b;
    tx_enable = 1'b1;
    wait_busy(1'b1, 100, a);
    wait_busy(1'b0, 5000, b);
    tick();
    ok = a && b;
  endtask

  function automatic logic [DW-1:0] rise_byte(input int s);
    logic [DW-1:0] b;
    if (rise_bits.size() < s + DW) return 'x;
    b = '0;
    for (int i = 0; i < DW; i++) b = {b[DW-2:0], rise_bits[s+i]};
    return b;
  endfunction

  function automatic logic [DW-1:0] rx_at(input int i);
    if (i >= rx_q.size()) return 'x;
    return rx_q[i];
  endfunction

  function automatic int cs_at(input int i);
    if (i >= cs_len_q.size()) return -1;
    return cs_len_q[i];
  endfunction

  function automatic int low_at(input int i);
    if (i >= low_run_q.size()) return -1;
    return low_run_q[i];
  endfunction

  function automatic logic rvf_at(input int i);
    if (i >= rv_fall_q.size()) return 1'bx;
    return rv_fall_q[i];
  endfunction

  // frame length with cs_n low: setup + n words + (n-1) FETCH/LOAD gaps + hold
  function automatic int frame_len(input int n);
    return SU + n * BYTE_CYC + 2 * (n - 1) + HD + 1;
  endfunction

  typedef struct {
    logic [DW-1:0] tx;
    logic          lp;
    logic [DW-1:0] pat;
    logic [DW-1:0] exp_rx;
    int            exp_cs;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int r0, x0, c0, l0, e0, bad;
    bit ok;

    tbl[0] = '{tx: 8'hA5, lp: 1'b1, pat: 8'h00, exp_rx: 8'hA5, exp_cs: SU + BYTE_CYC + HD + 1};
    tbl[1] = '{tx: 8'h00, lp: 1'b0, pat: 8'hC3, exp_rx: 8'hC3, exp_cs: SU + BYTE_CYC + HD + 1};
    tbl[2] = '{tx: 8'hFF, lp: 1'b0, pat: 8'h00, exp_rx: 8'h00, exp_cs: SU + BYTE_CYC + HD + 1};
    tbl[3] = '{tx: 8'h01, lp: 1'b0, pat: 8'h80, exp_rx: 8'h80, exp_cs: SU + BYTE_CYC + HD + 1};

    // reset state
    #2 rd_rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {cs_n, sclk, mosi, rd_en, rx_valid, busy}, 6'b100000);
    chk("reset_rx_data", rx_data, 8'h00);
    rd_rst_n = 1'b1;
    repeat (2) tick();

    // single-word frames from the table
    for (int v = 0; v < 4; v++) begin
      r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size(); e0 = n_rden;
      loop_en = tbl[v].lp; slave_pat = tbl[v].pat;
      push(tbl[v].tx);
      run_frame(ok);
      tx_enable = 1'b0;
      chk($sformatf("v%0d_done", v), ok, 1);
      chk($sformatf("v%0d_rd_en", v), n_rden - e0, 1);
      chk($sformatf("v%0d_mosi", v), rise_byte(r0), tbl[v].tx);
      chk($sformatf("v%0d_rx", v), rx_at(x0), tbl[v].exp_rx);
      chk($sformatf("v%0d_cs_len", v), cs_at(c0), tbl[v].exp_cs);
      chk($sformatf("v%0d_rv_at_fall", v), rvf_at(x0), 1);
      repeat (3) tick();
    end
    chk("sclk_high_phase", hi_bad, 0);

    // back-to-back words in one frame
    r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size();
    l0 = low_run_q.size(); e0 = n_rden;
    loop_en = 1'b1;
    push(8'h3C); push(8'hFF);
    run_frame(ok);
    tx_enable = 1'b0;
    chk("b2b_done", ok, 1);
    chk("b2b_rises", rise_bits.size() - r0, 2 * DW);
    chk("b2b_frames", cs_len_q.size() - c0, 1);
    chk("b2b_cs_len", cs_at(c0), frame_len(2));
    chk("b2b_rd_en", n_rden - e0, 2);
    chk("b2b_rx0", rx_at(x0), 8'h3C);
    chk("b2b_rx1", rx_at(x0 + 1), 8'hFF);
    chk("b2b_mosi1", rise_byte(r0 + DW), 8'hFF);
    chk("b2b_first_low", low_at(l0), SU + CD);
    chk("b2b_boundary_low", low_at(l0 + DW), 2 + CD);
    chk("b2b_inner_low", low_at(l0 + DW + 1), CD);
    repeat (3) tick();

    // empty FIFO with enable held
    e0 = n_rden; bad = 0;
    tx_enable = 1'b1;
    repeat (100) begin
      tick();
      if (rd_en || !cs_n || sclk || busy) bad++;
    end
    tx_enable = 1'b0;
    chk("empty_bad_cycles", bad, 0);
    chk("empty_rd_en", n_rden - e0, 0);

    // enable dropped mid-word with a second word queued
    r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size(); e0 = n_rden;
    push(8'h81); push(8'h42);
    tx_enable = 1'b1;
    wait_rise(r0 + 3, 500, ok);
    chk("drop_reach_bit3", ok, 1);
    tx_enable = 1'b0;
    wait_busy(1'b0, 2000, ok);
    tick();
    chk("drop_done", ok, 1);
    chk("drop_rx", rx_at(x0), 8'h81);
    chk("drop_rx_count", rx_q.size() - x0, 1);
    chk("drop_rd_en", n_rden - e0, 1);
    chk("drop_cs_len", cs_at(c0), frame_len(1));
    chk("drop_left_queued", rd_empty, 1'b0);
    repeat (4) tick();
    r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size();
    run_frame(ok);
    tx_enable = 1'b0;
    chk("resume_done", ok, 1);
    chk("resume_mosi", rise_byte(r0), 8'h42);
    chk("resume_rx", rx_at(x0), 8'h42);
    chk("resume_cs_len", cs_at(c0), frame_len(1));
    repeat (3) tick();

    // asynchronous reset mid-word
    r0 = rise_bits.size();
    push(8'h99);
    tx_enable = 1'b1;
    wait_rise(r0 + 4, 500, ok);
    chk("rst_reach_bit4", ok, 1);
    #2 rd_rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {cs_n, sclk, mosi, rd_en, rx_valid, busy}, 6'b100000);
    chk("rst_mid_rx_data", rx_data, 8'h00);
    tx_enable = 1'b0;
    repeat (3) tick();
    rd_rst_n = 1'b1;
    repeat (2) tick();
    r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size(); e0 = n_rden;
    push(8'h55);
    run_frame(ok);
    tx_enable = 1'b0;
    chk("post_rst_done", ok, 1);
    chk("post_rst_mosi", rise_byte(r0), 8'h55);
    chk("post_rst_rx", rx_at(x0), 8'h55);
    chk("post_rst_cs_len", cs_at(c0), frame_len(1));
    chk("post_rst_rd_en", n_rden - e0, 1);
    repeat (3) tick();

    // randomized frames against the frame-level model
    for (int f = 0; f < 6; f++) begin
      int n;
      logic [DW-1:0] b [3];
      n = $urandom_range(1, 3);
      loop_en = 1'($urandom_range(0, 1));
      slave_pat = DW'($urandom);
      r0 = rise_bits.size(); x0 = rx_q.size(); c0 = cs_len_q.size(); e0 = n_rden;
      for (int k = 0; k < n; k++) begin
        b[k] = DW'($urandom);
        push(b[k]);
      end
      run_frame(ok);
      tx_enable = 1'b0;
      chk($sformatf("rnd%0d_done", f), ok, 1);
      chk($sformatf("rnd%0d_cs_len", f), cs_at(c0), frame_len(n));
      chk($sformatf("rnd%0d_rd_en", f), n_rden - e0, n);
      for (int k = 0; k < n; k++) begin
        chk($sformatf("rnd%0d_mosi%0d", f, k), rise_byte(r0 + k * DW), b[k]);
        chk($sformatf("rnd%0d_rx%0d", f, k), rx_at(x0 + k), loop_en ? b[k] : slave_pat);
      end
      repeat ($urandom_range(1, 5)) tick();
    end

    chk("bus_invariants", inv_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
